// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch and decode/control blocks:
// instruction width, field bit positions, opcode map, fetch state encoding
// and the opcode legality helper.
package cpu_isa_pkg;

    localparam int INSTR_W = 32;

    localparam int OP_W  = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 16;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD      = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB      = 6'd1;
    localparam logic [OP_W-1:0] OP_MUL      = 6'd2;
    localparam logic [OP_W-1:0] OP_AND      = 6'd3;
    localparam logic [OP_W-1:0] OP_OR       = 6'd4;
    localparam logic [OP_W-1:0] OP_LBD      = 6'd10;
    localparam logic [OP_W-1:0] OP_LDW      = 6'd11;
    localparam logic [OP_W-1:0] OP_STB      = 6'd12;
    localparam logic [OP_W-1:0] OP_STW      = 6'd13;
    localparam logic [OP_W-1:0] OP_MOV      = 6'd14;
    localparam logic [OP_W-1:0] OP_BEQ      = 6'd20;
    localparam logic [OP_W-1:0] OP_JUMP     = 6'd21;
    localparam logic [OP_W-1:0] OP_TLBWRITE = 6'd30;
    localparam logic [OP_W-1:0] OP_IRET     = 6'd31;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // True when the opcode is part of the supported instruction map.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op_in);
        case (op_in)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR,
            OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
            OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, one-entry instruction
// buffer presented to decode, branch redirect with squash of in-flight data.
// Optional build macro: ILLEGAL_OP_EN (registers an illegal-opcode flag with
// the held instruction; when undefined illegal_op is tied low).
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  FETCH | imem_req high at fetch_pc, waiting for gnt
//  WAIT  | request accepted, waiting for rvalid (squash drops the word)
//  HOLD  | instruction held for decode until dec_ready or a redirect
module instr_fetch
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    input  logic                dec_ready,
    output logic [OP_W-1:0]     op,
    output logic [REG_W-1:0]    rs,
    output logic [REG_W-1:0]    rt,
    output logic [REG_W-1:0]    rd,
    output logic [IMM_W-1:0]    imm16,
    output logic [ADDR_W-1:0]   pc,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                illegal_op
);

    fetch_state_t         state, state_next;
    logic [ADDR_W-1:0]    fetch_pc, fetch_pc_next;
    logic                 squash, squash_next;
    logic                 load_instr;
    logic [INSTR_W-1:0]   instr_q;
    logic [ADDR_W-1:0]    pc_q;

    // State, fetch address and squash flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            squash   <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            squash   <= squash_next;
        end
    end

    // Next-state logic; a redirect overrides the fetch address in every state.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        squash_next   = squash;
        load_instr    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_gnt) begin
                    state_next  = WAIT;
                    squash_next = branch_taken;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    squash_next = 1'b0;
                    // A redirect arriving with the data kills that word too.
                    if (squash || branch_taken) begin
                        state_next = FETCH;
                    end else begin
                        state_next    = HOLD;
                        load_instr    = 1'b1;
                        fetch_pc_next = fetch_pc + ADDR_W'(4);
                    end
                end else if (branch_taken) begin
                    squash_next = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken || dec_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
        if (branch_taken) begin
            fetch_pc_next = branch_target & ~ADDR_W'(3);
        end
    end

    // Held instruction word and its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_instr) begin
            instr_q <= imem_rdata;
            pc_q    <= fetch_pc;
        end
    end

`ifdef ILLEGAL_OP_EN
    logic illegal_q;

    // Illegal-opcode flag captured alongside the instruction word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (load_instr) begin
            illegal_q <= ~is_legal_op(imem_rdata[OP_MSB:OP_LSB]);
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // The request is suppressed while reset is asserted even though the
    // state register already sits in FETCH.
    assign imem_req    = rst_n && (state == FETCH);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (state == HOLD);
    assign op          = instr_q[OP_MSB:OP_LSB];
    assign rs          = instr_q[RS_MSB:RS_LSB];
    assign rt          = instr_q[RT_MSB:RT_LSB];
    assign rd          = instr_q[RD_MSB:RD_LSB];
    assign imm16       = instr_q[IMM_MSB:IMM_LSB];
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: request/hold model plus directed
// scenarios with literal expectations.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        dec_ready;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .dec_ready(dec_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc(pc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic legal_op(input logic [5:0] o);
        int legal_list[14] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14, 20, 21, 30, 31};
        for (int i = 0; i < 14; i++)
            if (int'(o) == legal_list[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Model: at most one request in flight (possibly killed by a redirect),
    // at most one instruction held; next_addr is where the next fetch goes.
    logic        m_out_valid, m_out_killed, m_held;
    logic [31:0] m_out_addr, m_held_addr, m_held_word, m_next;
    int          m_hs = 0;
    logic        m_exp_req;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out_valid  <= 1'b0;
            m_out_killed <= 1'b0;
            m_out_addr   <= '0;
            m_held       <= 1'b0;
            m_held_addr  <= '0;
            m_held_word  <= '0;
            m_next       <= 32'h0;
        end else begin
            if (m_held) begin
                if (branch_taken || dec_ready) m_held <= 1'b0;
                if (!branch_taken && dec_ready) m_hs <= m_hs + 1;
            end else if (m_out_valid) begin
                if (imem_rvalid) begin
                    m_out_valid <= 1'b0;
                    if (!m_out_killed && !branch_taken) begin
                        m_held      <= 1'b1;
                        m_held_addr <= m_out_addr;
                        m_held_word <= imem_rdata;
                        m_next      <= m_out_addr + 32'd4;
                    end
                end else if (branch_taken) begin
                    m_out_killed <= 1'b1;
                end
            end else if (imem_gnt) begin
                m_out_valid  <= 1'b1;
                m_out_addr   <= m_next;
                m_out_killed <= branch_taken;
            end
            if (branch_taken) m_next <= {branch_target[31:2], 2'b00};
        end
    end

    assign m_exp_req = !m_out_valid && !m_held;

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req", imem_req, 0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_fields", {op, rs, rt, rd, imm16}, 0);
            chk("rst_pc", pc, 0);
            chk("rst_illegal", illegal_op, 0);
        end else begin
            chk("req", imem_req, m_exp_req);
            if (m_exp_req) chk("addr", imem_addr, m_next);
            chk("valid", instr_valid, m_held);
            if (m_held) begin
                chk("op", op, m_held_word[31:26]);
                chk("rs", rs, m_held_word[25:21]);
                chk("rt", rt, m_held_word[20:16]);
                chk("rd", rd, m_held_word[15:11]);
                chk("imm16", imm16, m_held_word[15:0]);
                chk("pc", pc, m_held_addr);
`ifdef ILLEGAL_OP_EN
                chk("illegal", illegal_op, !legal_op(m_held_word[31:26]));
`endif
            end
`ifndef ILLEGAL_OP_EN
            chk("illegal_tied", illegal_op, 0);
`endif
        end
    end

    // Entered at a falling edge in FETCH; returns at a falling edge in HOLD.
    task automatic issue(input logic [31:0] word, input int gnt_delay, input int lat);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) chk("req_timeout", imem_req, 1);
        repeat (gnt_delay) @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (lat - 1) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic accept();
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (3) @(negedge clk);

        // 1: release with gnt already high, rvalid one cycle later.
        imem_gnt = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0443_2800;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("t1_valid", instr_valid, 1);
        chk("t1_op", op, 6'd1);
        chk("t1_rs", rs, 5'd2);
        chk("t1_rt", rt, 5'd3);
        chk("t1_rd", rd, 5'd5);
        chk("t1_imm", imm16, 16'h2800);
        chk("t1_pc", pc, 32'h0);
        accept();
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", imem_req, 1);

        // 2: decode stalls for 5 cycles; stray rvalid while held is ignored.
        issue(32'h0862_1234, 0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF; end
            else imem_rvalid = 1'b0;
            @(negedge clk);
            chk("t2_valid", instr_valid, 1);
            chk("t2_noreq", imem_req, 0);
            chk("t2_pc", pc, 32'h4);
            chk("t2_op", op, 6'd2);
        end
        imem_rvalid = 1'b0;
        accept();
        chk("t2_next_addr", imem_addr, 32'h8);

        // 3: redirect during WAIT squashes the returning word.
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'h103;
        @(negedge clk);
        branch_taken = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("t3_valid", instr_valid, 0);
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h100);
        issue(32'h2C00_0010, 1, 1);
        chk("t3_pc", pc, 32'h100);
        accept();
        chk("t3_hs", m_hs, 3);

        // 4: redirect in HOLD with dec_ready high drops the instruction.
        issue(32'h5000_0000, 0, 1);
        branch_taken = 1'b1; branch_target = 32'h200; dec_ready = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0; dec_ready = 1'b0;
        chk("t4_valid", instr_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_hs", m_hs, 3);

        // 5: gnt withheld, then reset pulsed in the middle of WAIT.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_req_hold", imem_req, 1);
            chk("t5_addr_hold", imem_addr, 32'h200);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_req", imem_req, 0);
        chk("t5_rst_valid", instr_valid, 0);
        chk("t5_rst_pc", pc, 0);
        chk("t5_rst_op", op, 0);
        chk("t5_rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_req_after", imem_req, 1);
        chk("t5_addr_after", imem_addr, 32'h0);
        issue(32'h0000_0000, 0, 1);
        accept();

        // Redirect in FETCH without gnt, then address wrap past the top.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        issue(32'h3800_0001, 0, 1);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        accept();
        chk("wrap_next", imem_addr, 32'h0);

        // Redirect on the same edge as gnt: the granted word is squashed.
        imem_gnt = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        imem_gnt = 1'b0; branch_taken = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("sq_valid", instr_valid, 0);
        chk("sq_addr", imem_addr, 32'h40);

        // 6: illegal opcode flag.
        issue({6'd7, 26'h0}, 0, 1);
        chk("t6_op7", op, 6'd7);
`ifdef ILLEGAL_OP_EN
        chk("t6_ill7", illegal_op, 1);
`else
        chk("t6_ill7", illegal_op, 0);
`endif
        accept();
        issue({6'd31, 26'h155}, 0, 1);
        chk("t6_op31", op, 6'd31);
        chk("t6_ill31", illegal_op, 0);
        accept();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
